// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI shift engine: FSM state encoding,
// frame-length clamp and the N-bit mask used by the datapath.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } spi_state_e;

  // A frame length of zero or beyond the register width means "full width".
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
    return ((len == 0) || (len > max_len)) ? max_len : len;
  endfunction

  // Low n bits set; n may be as large as 32.
  function automatic logic [31:0] len_mask(input int unsigned n);
    return 32'((64'd1 << n) - 64'd1);
  endfunction

endpackage

// File: rtl/spi_shift_engine_if.sv
// Handshake and serial bundle between a frame controller (master) and the
// shift engine (slave).
interface spi_shift_engine_if #(
  parameter int unsigned DATA_LEN = 8
);
  localparam int unsigned LEN_W = $clog2(DATA_LEN + 1);

  logic [DATA_LEN-1:0] data_in;
  logic                load;
  logic [LEN_W-1:0]    frame_len;
  logic                msb_first;
  logic                sample_tick;
  logic                shift_tick;
  logic                serial_in;
  logic                serial_out;
  logic                busy;
  logic                done;
  logic [DATA_LEN-1:0] data_out;
  logic                rx_valid;
  logic                rx_ack;
  logic                rx_overrun;

  modport master (
    output data_in, load, frame_len, msb_first, sample_tick, shift_tick,
           serial_in, rx_ack,
    input  serial_out, busy, done, data_out, rx_valid, rx_overrun
  );

  modport slave (
    input  data_in, load, frame_len, msb_first, sample_tick, shift_tick,
           serial_in, rx_ack,
    output serial_out, busy, done, data_out, rx_valid, rx_overrun
  );

endinterface

// File: rtl/spi_bit_counter.sv
// Bit counter for one frame; terminal_c flags the increment that reaches len_i.
module spi_bit_counter #(
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             inc_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             terminal_c
);

  logic [LEN_W-1:0] count_q;
  logic [LEN_W-1:0] count_d;
  logic [LEN_W-1:0] count_inc;

  always_comb begin
    count_inc = count_q + LEN_W'(1);
    count_d   = count_q;
    if (load_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_inc;
    end
  end

  assign terminal_c = inc_i && !load_i && (count_inc == len_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/spi_shift_engine.sv
// Configurable-length, bit-order-selectable SPI shift engine.
// Define SPI_SHIFT_ENGINE_RXBUF_EN to add a receive holding register with valid/ack/overrun.
module spi_shift_engine
  import spi_pkg::*;
#(
  parameter int unsigned DATA_LEN = 8
) (
  input logic              clk,
  input logic              rst,
  spi_shift_engine_if.slave bus
);

  localparam int unsigned LEN_W = $clog2(DATA_LEN + 1);

  spi_state_e          state_q;
  logic [DATA_LEN-1:0] sr_q, sr_d;
  logic [DATA_LEN-1:0] sr_shr;
  logic [DATA_LEN-1:0] mask_q;
  logic [LEN_W-1:0]    n_q, n_d;
  logic                msb_q, msb_d;
  logic                rx_q, rx_d;
  logic                rx_eff;
  logic                load_acc;
  logic                shift_en;
  logic                sample_en;
  logic                enter_done;
  logic                terminal_c;
  logic                so_d;

  logic                serial_out_q;
  logic                busy_q;
  logic                done_q;
  logic [DATA_LEN-1:0] data_out_q;
  logic                rx_valid_q;
  logic                rx_overrun_q;

  spi_bit_counter #(
    .LEN_W (LEN_W)
  ) u_bit_counter (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load_acc),
    .inc_i      (shift_en),
    .len_i      (n_q),
    .terminal_c (terminal_c)
  );

  // Next shift-register contents, frame settings and the serial bit they expose.
  always_comb begin
    load_acc   = bus.load && (state_q != SHIFT);
    shift_en   = bus.shift_tick && (state_q == SHIFT);
    sample_en  = bus.sample_tick && (state_q == SHIFT);
    enter_done = (state_q == SHIFT) && terminal_c;
    // A coincident sample tick feeds the same-cycle serial_in into the shift.
    rx_eff     = sample_en ? bus.serial_in : rx_q;
    rx_d       = rx_eff;
    mask_q     = DATA_LEN'(len_mask(32'(n_q)));
    n_d        = n_q;
    msb_d      = msb_q;
    sr_d       = sr_q;
    if (load_acc) begin
      n_d   = LEN_W'(clamp_len(32'(bus.frame_len), DATA_LEN));
      msb_d = bus.msb_first;
      sr_d  = bus.data_in & DATA_LEN'(len_mask(32'(n_d)));
    end else if (shift_en) begin
      if (msb_q) begin
        sr_d = ((sr_q << 1) | DATA_LEN'(rx_eff)) & mask_q;
      end else begin
        sr_d = (sr_q >> 1) | (DATA_LEN'(rx_eff) << (n_q - LEN_W'(1)));
      end
    end
    sr_shr = sr_d >> (n_d - LEN_W'(1));
    so_d   = msb_d ? sr_shr[0] : sr_d[0];
  end

  // Frame FSM with registered status, serial and receive outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sr_q         <= '0;
      n_q          <= LEN_W'(DATA_LEN);
      msb_q        <= 1'b0;
      rx_q         <= 1'b0;
      serial_out_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      data_out_q   <= '0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      sr_q         <= sr_d;
      n_q          <= n_d;
      msb_q        <= msb_d;
      rx_q         <= rx_d;
      serial_out_q <= so_d;
      case (state_q)
        SHIFT: begin
          if (terminal_c) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        default: begin
          if (load_acc) begin
            state_q <= SHIFT;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          done_q <= 1'b0;
        end
      endcase
`ifdef SPI_SHIFT_ENGINE_RXBUF_EN
      if (enter_done) begin
        data_out_q <= sr_d;
        rx_valid_q <= 1'b1;
        if (rx_valid_q && !bus.rx_ack) begin
          rx_overrun_q <= 1'b1;
        end
      end else if (bus.rx_ack) begin
        rx_valid_q <= 1'b0;
      end
`else
      data_out_q   <= sr_d;
      rx_valid_q   <= enter_done;
      rx_overrun_q <= 1'b0;
`endif
    end
  end

`ifndef SPI_SHIFT_ENGINE_RXBUF_EN
  logic unused_rx_ack;
  assign unused_rx_ack = bus.rx_ack;
`endif

  assign bus.serial_out = serial_out_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.data_out   = data_out_q;
  assign bus.rx_valid   = rx_valid_q;
  assign bus.rx_overrun = rx_overrun_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine: frame-level reference model checked every
// cycle, plus literal expectations for the documented frames.
module tb_spi_shift_engine;

  localparam int unsigned DATA_LEN = 8;
`ifdef SPI_SHIFT_ENGINE_RXBUF_EN
  localparam bit RXBUF = 1'b1;
`else
  localparam bit RXBUF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_shift_engine_if #(.DATA_LEN(DATA_LEN)) bus ();

  spi_shift_engine #(.DATA_LEN(DATA_LEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: original word, length, order, bits shifted so far, bits received.
  int       ph;
  int       k;
  int       mn;
  bit       mmsb;
  bit [7:0] mtx;
  bit       mrx;
  bit       rxs [8];
  bit [7:0] mhold;
  bit       mval;
  bit       movr;
  bit       enter;
  bit       b;
  bit [7:0] exp_sr;

  function automatic bit [7:0] mask(input int n);
    return 8'((16'd1 << n) - 16'd1);
  endfunction

  // Register image after k shifts: untransmitted TX bits plus received bits.
  function automatic bit [7:0] model_sr();
    bit [7:0] s;
    s = '0;
    for (int p = 0; p < mn; p++) begin
      if (mmsb) s[p] = (p >= k) ? mtx[p-k] : rxs[k-1-p];
      else      s[p] = (p < mn - k) ? mtx[p+k] : rxs[p-(mn-k)];
    end
    return s;
  endfunction

  initial forever begin
    @(posedge clk);
    if (rst) begin
      ph = 0; k = 0; mtx = '0; mn = DATA_LEN; mmsb = 1'b0; mrx = 1'b0;
      mhold = '0; mval = 1'b0; movr = 1'b0;
    end else begin
      enter = 1'b0;
      if (ph == 1) begin
        b = bus.sample_tick ? bus.serial_in : mrx;
        if (bus.sample_tick) mrx = bus.serial_in;
        if (bus.shift_tick) begin
          rxs[k] = b;
          k++;
          if (k == mn) begin
            ph    = 2;
            enter = 1'b1;
          end
        end
      end else if (bus.load) begin
        mn   = (bus.frame_len == 0 || bus.frame_len > DATA_LEN) ? DATA_LEN : int'(bus.frame_len);
        mtx  = bus.data_in & mask(mn);
        mmsb = bus.msb_first;
        k    = 0;
        ph   = 1;
      end else begin
        ph = 0;
      end
      if (RXBUF) begin
        if (enter) begin
          if (mval && !bus.rx_ack) movr = 1'b1;
          mval  = 1'b1;
          mhold = model_sr();
        end else if (bus.rx_ack) begin
          mval = 1'b0;
        end
      end else begin
        mval = enter;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      exp_sr = model_sr();
      check("busy",       32'(bus.busy),       32'(ph == 1));
      check("done",       32'(bus.done),       32'(ph == 2));
      check("serial_out", 32'(bus.serial_out), 32'(mmsb ? exp_sr[mn-1] : exp_sr[0]));
      check("data_out",   32'(bus.data_out),   32'(RXBUF ? mhold : exp_sr));
      check("rx_valid",   32'(bus.rx_valid),   32'(mval));
      check("rx_overrun", 32'(bus.rx_overrun), 32'(movr));
    end
  end

  task automatic start(input logic [7:0] d, input logic [3:0] len, input logic m);
    bus.data_in   = d;
    bus.frame_len = len;
    bus.msb_first = m;
    bus.load      = 1'b1;
    @(negedge clk);
    bus.load      = 1'b0;
    bus.data_in   = '0;
  endtask

  task automatic shift_bit(input logic sin);
    bus.sample_tick = 1'b1;
    bus.shift_tick  = 1'b1;
    bus.serial_in   = sin;
    @(negedge clk);
    bus.sample_tick = 1'b0;
    bus.shift_tick  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  bit so1 [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
  bit so2 [5] = '{1, 0, 0, 1, 1};
  bit rx2 [5] = '{1, 1, 0, 0, 1};
  bit so7 [4] = '{1, 0, 0, 1};

  initial begin
    bus.data_in = '0; bus.load = 1'b0; bus.frame_len = '0; bus.msb_first = 1'b0;
    bus.sample_tick = 1'b0; bus.shift_tick = 1'b0; bus.serial_in = 1'b0; bus.rx_ack = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_data", 32'(bus.data_out), 32'd0);
    rst = 1'b0;
    idle(1);

    // LSB-first 0xA5 with serial_in looped back.
    start(8'hA5, 4'd8, 1'b0);
    for (int i = 0; i < 8; i++) begin
      check("t1_so", 32'(bus.serial_out), 32'(so1[i]));
      check("t1_done_early", 32'(bus.done), 32'd0);
      shift_bit(bus.serial_out);
    end
    check("t1_done", 32'(bus.done), 32'd1);
    check("t1_busy", 32'(bus.busy), 32'd0);
    check("t1_data", 32'(bus.data_out), 32'hA5);
    idle(1);
    check("t1_done_clr", 32'(bus.done), 32'd0);

    // MSB-first 5-bit frame with driven receive bits.
    start(8'h13, 4'd5, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("t2_so", 32'(bus.serial_out), 32'(so2[i]));
      shift_bit(rx2[i]);
    end
    check("t2_done", 32'(bus.done), 32'd1);
    check("t2_data", 32'(bus.data_out), 32'h19);
    idle(1);

    // Load mid-frame is ignored.
    start(8'h5A, 4'd8, 1'b1);
    repeat (3) shift_bit(bus.serial_out);
    bus.data_in = 8'hFF;
    bus.load    = 1'b1;
    @(negedge clk);
    bus.load    = 1'b0;
    check("t3_busy", 32'(bus.busy), 32'd1);
    repeat (5) shift_bit(bus.serial_out);
    check("t3_done", 32'(bus.done), 32'd1);
    check("t3_data", 32'(bus.data_out), 32'h5A);

    // Back-to-back load from DONE; frame_len 0 means 8; split sample and shift.
    start(8'h3C, 4'd0, 1'b1);
    check("t4_busy", 32'(bus.busy), 32'd1);
    repeat (4) shift_bit(1'b1);
    for (int i = 0; i < 4; i++) begin
      bus.sample_tick = 1'b1; bus.serial_in = 1'b0;
      @(negedge clk);
      bus.sample_tick = 1'b0; bus.shift_tick = 1'b1; bus.serial_in = 1'b1;
      @(negedge clk);
      bus.shift_tick = 1'b0;
    end
    check("t4_done", 32'(bus.done), 32'd1);
    check("t4_data", 32'(bus.data_out), 32'hF0);
    idle(1);

    // Oversized frame_len clamps to 8, LSB-first insertion at bit 7.
    start(8'h0F, 4'd12, 1'b0);
    repeat (7) shift_bit(1'b1);
    check("t5_done_early", 32'(bus.done), 32'd0);
    check("t5_busy", 32'(bus.busy), 32'd1);
    shift_bit(1'b1);
    check("t5_done", 32'(bus.done), 32'd1);
    check("t5_data", 32'(bus.data_out), 32'hFF);
    idle(1);

    // Ticks outside a frame change nothing.
    bus.sample_tick = 1'b1; bus.shift_tick = 1'b1; bus.serial_in = 1'b0;
    idle(2);
    bus.sample_tick = 1'b0; bus.shift_tick = 1'b0;
    check("t6_data", 32'(bus.data_out), 32'hFF);
    check("t6_busy", 32'(bus.busy), 32'd0);

    // Reset mid-frame discards the frame.
    start(8'hC3, 4'd8, 1'b1);
    repeat (3) shift_bit(1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t7_busy", 32'(bus.busy), 32'd0);
    check("t7_done", 32'(bus.done), 32'd0);
    check("t7_so", 32'(bus.serial_out), 32'd0);
    check("t7_data", 32'(bus.data_out), 32'd0);
    check("t7_valid", 32'(bus.rx_valid), 32'd0);
    check("t7_ovr", 32'(bus.rx_overrun), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t7_no_done", 32'(bus.done), 32'd0);
    end
    start(8'h09, 4'd4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("t7_so2", 32'(bus.serial_out), 32'(so7[i]));
      shift_bit(bus.serial_out);
    end
    check("t7_done2", 32'(bus.done), 32'd1);
    check("t7_data2", 32'(bus.data_out), 32'h09);
    idle(1);

`ifdef SPI_SHIFT_ENGINE_RXBUF_EN
    // Two words without acknowledge: overrun, newest word kept.
    start(8'h05, 4'd4, 1'b1);
    repeat (4) shift_bit(bus.serial_out);
    check("t8_valid1", 32'(bus.rx_valid), 32'd1);
    check("t8_ovr1", 32'(bus.rx_overrun), 32'd0);
    idle(2);
    check("t8_hold", 32'(bus.data_out), 32'h05);
    start(8'h0A, 4'd4, 1'b1);
    repeat (4) shift_bit(bus.serial_out);
    check("t8_ovr2", 32'(bus.rx_overrun), 32'd1);
    check("t8_data2", 32'(bus.data_out), 32'h0A);
    bus.rx_ack = 1'b1;
    @(negedge clk);
    bus.rx_ack = 1'b0;
    check("t8_ack", 32'(bus.rx_valid), 32'd0);
    check("t8_ovr_sticky", 32'(bus.rx_overrun), 32'd1);
    idle(1);
`else
    // rx_valid mirrors done and rx_ack has no effect.
    bus.rx_ack = 1'b1;
    start(8'h05, 4'd4, 1'b1);
    repeat (4) shift_bit(bus.serial_out);
    check("t8_valid", 32'(bus.rx_valid), 32'd1);
    check("t8_ovr", 32'(bus.rx_overrun), 32'd0);
    check("t8_data", 32'(bus.data_out), 32'h05);
    idle(1);
    check("t8_valid_clr", 32'(bus.rx_valid), 32'd0);
    bus.rx_ack = 1'b0;
    idle(1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_shift_engine.md
SPI_SHIFT_ENGINE -- requirements
Module: spi_shift_engine

Interface
REQ-001 SHALL have parameter DATA_LEN, default 8, meaning maximum frame width in bits (legal range 2..32).
REQ-002 SHALL have localparam LEN_W = $clog2(DATA_LEN+1), meaning frame-length field width.
REQ-003 SHALL have port clk  in  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port data_in  in  DATA_LEN  parallel TX word, right-aligned.
REQ-006 SHALL have port load  in  1  start frame; capture data_in, frame_len, msb_first.
REQ-007 SHALL have port frame_len  in  LEN_W  bits per frame, 1..DATA_LEN.
REQ-008 SHALL have port msb_first  in  1  bit order: 1 = MSB-first, 0 = LSB-first.
REQ-009 SHALL have port sample_tick  in  1  capture serial_in into the internal rx bit.
REQ-010 SHALL have port shift_tick  in  1  shift register, advance bit counter.
REQ-011 SHALL have port serial_in  in  1  MISO/MOSI input.
REQ-012 SHALL have port serial_out  out  1  MOSI/MISO output.
REQ-013 SHALL have port busy  out  1  frame in progress.
REQ-014 SHALL have port done  out  1  one-cycle frame-complete pulse.
REQ-015 SHALL have port data_out  out  DATA_LEN  received word, right-aligned, upper bits zero.
REQ-016 SHALL have ports rx_valid (out 1), rx_ack (in 1) and rx_overrun (out 1), meaning receive-buffer handshake.

Function
REQ-017 SHALL implement the FSM IDLE -> SHIFT on accepted load; SHIFT -> DONE on the shift_tick that makes count == frame_len; DONE -> IDLE after one cycle.
REQ-018 SHALL accept load only in IDLE or DONE; load in SHIFT is ignored with no state change.
REQ-019 SHALL clamp frame_len of 0 or greater than DATA_LEN to DATA_LEN at capture.
REQ-020 SHALL, on accepted load, set sr = data_in masked to N = frame_len bits and clear count; serial_out shows the first bit the next cycle.
REQ-021 SHALL drive serial_out as sr[N-1] when MSB-first and sr[0] when LSB-first, in every state.
REQ-022 SHALL, in MSB-first mode, shift sr left by one on shift_tick, insert the rx bit at bit 0 and zero bits N and above.
REQ-023 SHALL, in LSB-first mode, shift sr right by one on shift_tick and insert the rx bit at bit N-1.
REQ-024 SHALL latch serial_in into the rx bit on sample_tick in SHIFT; when sample_tick and shift_tick coincide, the shift inserts the current serial_in.
REQ-025 SHALL ignore both ticks outside SHIFT.
REQ-026 SHALL assert busy only in SHIFT, and assert done only in DONE, i.e. exactly one cycle after the final shift_tick.
REQ-027 SHALL update data_out continuously from sr, masked to N bits.

Reset
REQ-028 SHALL, on rst (including mid-frame), enter IDLE and clear sr, count, rx bit, serial_out, busy, done, data_out, rx_valid and rx_overrun to 0; a partial frame is discarded with no done pulse.

Configuration
REQ-029 SHALL, with SPI_SHIFT_ENGINE_RXBUF_EN defined, load a holding register from sr on entering DONE, drive data_out from that register, set rx_valid on DONE and clear it on rx_ack.
REQ-030 SHALL, with SPI_SHIFT_ENGINE_RXBUF_EN defined, set sticky rx_overrun when DONE occurs with rx_valid=1 and rx_ack=0; the new word still overwrites, and rx_overrun clears only on rst.
REQ-031 SHALL, without SPI_SHIFT_ENGINE_RXBUF_EN, drive data_out per REQ-027, make rx_valid equal to done, tie rx_overrun to 0 and ignore rx_ack.

Structure
REQ-032 SHALL place the FSM state enum (IDLE/SHIFT/DONE) and the frame-length clamp function in shared package spi_pkg.
REQ-033 SHALL implement the counter and compare as sub-module spi_bit_counter (load, inc, len, terminal).

Verification
REQ-034 SHALL cover: DATA_LEN=8, N=8, LSB-first, data_in=0xA5, serial_in looped to serial_out -> serial_out 1,0,1,0,0,1,0,1; done one cycle after the 8th tick; data_out=0xA5.
REQ-035 SHALL cover: N=5, MSB-first, data_in=0x13, serial_in driven 1,1,0,0,1 -> serial_out 1,0,0,1,1; data_out=0x19.
REQ-036 SHALL cover: load pulsed mid-frame with data_in=0xFF -> ignored, frame completes with original data, busy stays 1.
REQ-037 SHALL cover: rst after 3 ticks -> IDLE, all outputs 0, no done; next load runs normally.
REQ-038 SHALL cover: frame_len=0 -> 8 bits shifted; simultaneous sample/shift ticks insert the same-cycle serial_in.
REQ-039 SHALL cover, with RXBUF_EN: two frames without rx_ack -> rx_overrun=1 and data_out = second word; rx_ack clears rx_valid.
